// File: rtl/function_return_pkg.sv
// Shared types for the function-return (frame pop) controller: FSM encoding and stats width.
package function_return_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_UFLOW = 3'd4
  } state_t;

  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/function_return.sv
// Function-return controller: pops one frame from the external return-address / saved-TOS stacks.
// Optional return counter output RET_COUNT is built when FUNCTION_RETURN_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for RET_REQ
// READ  | read address presented to the stack memories
// LATCH | memory data captured, frame pointer decrement pulsed
// HOLD  | restored frame presented until RET_ACK
// UFLOW | return requested with empty stack, underflow pulsed
module function_return
  import function_return_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RET_REQ,
  input  logic                  RET_ACK,
  input  logic [ADDR_WIDTH-1:0] FRAME_DEPTH_IN,
  input  logic [ADDR_WIDTH-1:0] STACK_FUNCTION_DATA_IN,
  input  logic [ADDR_WIDTH-1:0] STACK_TOS_DATA_IN,
  output logic [ADDR_WIDTH-1:0] STACK_RD_ADDR,
  output logic [ADDR_WIDTH-1:0] RET_PC_OUT,
  output logic [ADDR_WIDTH-1:0] RET_TOS_OUT,
  output logic                  RET_VALID,
  output logic                  RET_BUSY,
  output logic                  CTRL_DEPTH_DEC,
  output logic                  RET_UNDERFLOW
`ifdef FUNCTION_RETURN_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] RET_COUNT
`endif
);

  localparam int unused_data_width = DATA_WIDTH;

  state_t state, next_state;
  logic   accept;

  assign accept = (state == S_IDLE) && RET_REQ && (FRAME_DEPTH_IN != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (RET_REQ) next_state = (FRAME_DEPTH_IN != '0) ? S_READ : S_UFLOW;
      end
      S_READ:  next_state = S_LATCH;
      S_LATCH: next_state = S_HOLD;
      S_HOLD:  if (RET_ACK) next_state = S_IDLE;
      S_UFLOW: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs are gated by reset so a pop in flight leaves no pulse behind.
  always_comb begin
    RET_BUSY       = 1'b0;
    RET_VALID      = 1'b0;
    CTRL_DEPTH_DEC = 1'b0;
    RET_UNDERFLOW  = 1'b0;
    if (!reset) begin
      RET_BUSY       = (state != S_IDLE);
      RET_VALID      = (state == S_HOLD);
      CTRL_DEPTH_DEC = (state == S_LATCH);
      RET_UNDERFLOW  = (state == S_UFLOW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      STACK_RD_ADDR <= '0;
      RET_PC_OUT    <= '0;
      RET_TOS_OUT   <= '0;
    end else begin
      if (accept) STACK_RD_ADDR <= FRAME_DEPTH_IN - 1'b1;
      if (state == S_LATCH) begin
        RET_PC_OUT  <= STACK_FUNCTION_DATA_IN;
        RET_TOS_OUT <= STACK_TOS_DATA_IN;
      end
    end
  end

`ifdef FUNCTION_RETURN_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) RET_COUNT <= '0;
    else if (state == S_LATCH && RET_COUNT != {STATS_WIDTH{1'b1}})
      RET_COUNT <= RET_COUNT + 1'b1;
  end
`endif

endmodule

// File: tb/tb_function_return.sv
// Self-checking bench for function_return: directed table, hand-written corner sequences, random run vs model.
module tb_function_return;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, RET_REQ, RET_ACK;
  logic [AW-1:0] FRAME_DEPTH_IN, STACK_FUNCTION_DATA_IN, STACK_TOS_DATA_IN;
  logic [AW-1:0] STACK_RD_ADDR, RET_PC_OUT, RET_TOS_OUT;
  logic          RET_VALID, RET_BUSY, CTRL_DEPTH_DEC, RET_UNDERFLOW;
`ifdef FUNCTION_RETURN_STATS_EN
  logic [15:0]   RET_COUNT;
`endif

  always #5 clk = ~clk;

  function_return #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .RET_REQ(RET_REQ), .RET_ACK(RET_ACK),
    .FRAME_DEPTH_IN(FRAME_DEPTH_IN),
    .STACK_FUNCTION_DATA_IN(STACK_FUNCTION_DATA_IN),
    .STACK_TOS_DATA_IN(STACK_TOS_DATA_IN),
    .STACK_RD_ADDR(STACK_RD_ADDR), .RET_PC_OUT(RET_PC_OUT), .RET_TOS_OUT(RET_TOS_OUT),
    .RET_VALID(RET_VALID), .RET_BUSY(RET_BUSY), .CTRL_DEPTH_DEC(CTRL_DEPTH_DEC),
    .RET_UNDERFLOW(RET_UNDERFLOW)
`ifdef FUNCTION_RETURN_STATS_EN
    , .RET_COUNT(RET_COUNT)
`endif
  );

  // external stack memories with one-cycle read latency
  logic [AW-1:0] mem_pc [DEPTH];
  logic [AW-1:0] mem_tos[DEPTH];
  always @(posedge clk) begin
    STACK_FUNCTION_DATA_IN <= mem_pc[STACK_RD_ADDR];
    STACK_TOS_DATA_IN      <= mem_tos[STACK_RD_ADDR];
  end

  int checks = 0;
  int errors = 0;
  int dut_dec_count = 0;

  // reference model: a pop is tracked by its age in cycles since acceptance
  int            age;
  bit            m_uf;
  logic [AW-1:0] m_addr, m_pc, m_tos;
  int            m_count;
  bit            cur_rst, cur_req, cur_ack;
  logic [AW-1:0] cur_depth;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("busy",  32'(RET_BUSY),       32'(!cur_rst && (age != 0 || m_uf)));
    check("valid", 32'(RET_VALID),      32'(!cur_rst && age >= 3));
    check("dec",   32'(CTRL_DEPTH_DEC), 32'(!cur_rst && age == 2));
    check("uflow", 32'(RET_UNDERFLOW),  32'(!cur_rst && m_uf));
    check("addr",  32'(STACK_RD_ADDR),  32'(m_addr));
    check("pc",    32'(RET_PC_OUT),     32'(m_pc));
    check("tos",   32'(RET_TOS_OUT),    32'(m_tos));
`ifdef FUNCTION_RETURN_STATS_EN
    check("count", 32'(RET_COUNT),      32'(m_count));
`endif
  endtask

  task automatic model_step();
    if (cur_rst) begin
      age = 0; m_uf = 0; m_addr = '0; m_pc = '0; m_tos = '0; m_count = 0;
    end else if (m_uf) begin
      m_uf = 0;
    end else if (age == 0) begin
      if (cur_req) begin
        if (cur_depth != 0) begin
          m_addr = AW'((int'(cur_depth) + DEPTH - 1) % DEPTH);
          age = 1;
        end else m_uf = 1;
      end
    end else if (age == 2) begin
      m_pc = mem_pc[m_addr];
      m_tos = mem_tos[m_addr];
      if (m_count < 65535) m_count++;
      age = 3;
    end else if (age >= 3) begin
      if (cur_ack) age = 0; else age++;
    end else age++;
  endtask

  task automatic apply(input bit rst, input bit rq, input bit ak, input logic [AW-1:0] d);
    cur_rst = rst; cur_req = rq; cur_ack = ak; cur_depth = d;
    reset = rst; RET_REQ = rq; RET_ACK = ak; FRAME_DEPTH_IN = d;
    #1;
    if (CTRL_DEPTH_DEC === 1'b1) dut_dec_count++;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle(input bit rst, input bit rq, input bit ak, input logic [AW-1:0] d);
    apply(rst, rq, ak, d);
    advance();
  endtask

  typedef struct {
    bit rst, req, ack;
    logic [AW-1:0] depth;
    logic [AW-1:0] addr;
    bit valid, dec, busy, uf;
    logic [AW-1:0] pc, tos;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int dec_cycle[$];
    logic [AW-1:0] dec_addr[$];
    logic [AW-1:0] d;
    logic [AW-1:0] hold_pc, hold_tos;
    int base;

    for (int i = 0; i < DEPTH; i++) begin
      mem_pc[i]  = AW'($urandom);
      mem_tos[i] = AW'($urandom);
    end
    mem_pc[2] = 12'h123; mem_tos[2] = 12'h045;

    //            rst req ack depth addr valid dec busy uf  pc      tos
    tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 12'd3, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 12'd3, 12'd2, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 12'd3, 12'd2, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 12'd3, 12'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123, 12'h045};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 12'd3, 12'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123, 12'h045};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h045};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 12'd0, 12'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h045};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 12'h045};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h045};

    reset = 1; RET_REQ = 0; RET_ACK = 0; FRAME_DEPTH_IN = '0;
    cur_rst = 1; cur_req = 0; cur_ack = 0; cur_depth = '0;
    @(negedge clk);
    advance();

    // basic pop and underflow
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].depth);
      check($sformatf("t%0d_addr", i),  32'(STACK_RD_ADDR),  32'(tbl[i].addr));
      check($sformatf("t%0d_valid", i), 32'(RET_VALID),      32'(tbl[i].valid));
      check($sformatf("t%0d_dec", i),   32'(CTRL_DEPTH_DEC), 32'(tbl[i].dec));
      check($sformatf("t%0d_busy", i),  32'(RET_BUSY),       32'(tbl[i].busy));
      check($sformatf("t%0d_uf", i),    32'(RET_UNDERFLOW),  32'(tbl[i].uf));
      check($sformatf("t%0d_pc", i),    32'(RET_PC_OUT),     32'(tbl[i].pc));
      check($sformatf("t%0d_tos", i),   32'(RET_TOS_OUT),    32'(tbl[i].tos));
      advance();
    end

    // ACK withheld for 5 cycles in HOLD
    base = dut_dec_count;
    cycle(0, 1, 0, 3); cycle(0, 0, 1, 3); cycle(0, 0, 1, 3);
    apply(0, 0, 0, 3);
    hold_pc = RET_PC_OUT; hold_tos = RET_TOS_OUT;
    check("hold_pc_val", 32'(hold_pc), 32'h123);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 7);
      check("hold_valid", 32'(RET_VALID), 32'd1);
      check("hold_pc_stable", 32'(RET_PC_OUT), 32'(hold_pc));
      check("hold_tos_stable", 32'(RET_TOS_OUT), 32'(hold_tos));
      advance();
    end
    cycle(0, 0, 1, 3);
    apply(0, 0, 0, 3);
    check("ack_idle_busy", 32'(RET_BUSY), 32'd0);
    check("ack_idle_valid", 32'(RET_VALID), 32'd0);
    check("hold_dec_total", 32'(dut_dec_count - base), 32'd1);
    advance();

    // reset during LATCH
    cycle(0, 1, 0, 3); cycle(0, 0, 0, 3);
    apply(1, 0, 0, 3);
    check("rst_latch_dec", 32'(CTRL_DEPTH_DEC), 32'd0);
    advance();
    apply(0, 0, 0, 3);
    check("rst_after_busy", 32'(RET_BUSY), 32'd0);
    check("rst_after_addr", 32'(STACK_RD_ADDR), 32'd0);
    check("rst_after_pc", 32'(RET_PC_OUT), 32'd0);
    advance();
    cycle(0, 1, 0, 3); cycle(0, 0, 0, 3); cycle(0, 0, 0, 3);
    apply(0, 0, 1, 3);
    check("rst_recover_pc", 32'(RET_PC_OUT), 32'h123);
    check("rst_recover_tos", 32'(RET_TOS_OUT), 32'h045);
    advance();

    // back-to-back pops, stack owner decrements depth on each pulse
    d = 5;
    for (int i = 0; i < 14; i++) begin
      apply(0, i < 10, 1, d);
      if (CTRL_DEPTH_DEC === 1'b1) begin
        dec_cycle.push_back(i);
        dec_addr.push_back(STACK_RD_ADDR);
      end
      advance();
      if (dec_cycle.size() > 0 && dec_cycle[$] == i) d = d - 1'b1;
    end
    check("b2b_pops", 32'(dec_cycle.size()), 32'd3);
    if (dec_cycle.size() >= 2) begin
      check("b2b_addr0", 32'(dec_addr[0]), 32'd4);
      check("b2b_addr1", 32'(dec_addr[1]), 32'd3);
      check("b2b_gap", 32'(dec_cycle[1] - dec_cycle[0]), 32'd4);
    end

    // address wrap at full depth
    cycle(0, 1, 0, 12'hFFF);
    apply(0, 0, 0, 0);
    check("wrap_addr", 32'(STACK_RD_ADDR), 32'hFFE);
    advance();
    cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);

`ifdef FUNCTION_RETURN_STATS_EN
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 4); cycle(0, 0, 0, 4); cycle(0, 0, 0, 4); cycle(0, 0, 1, 4);
    end
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    check("stats_count", 32'(RET_COUNT), 32'd3);
    advance();
`endif

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] rd;
      if ($urandom_range(0, 7) == 0) rd = '0;
      else if ($urandom_range(0, 7) == 0) rd = AW'($urandom);
      else rd = AW'($urandom_range(1, 8));
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
